// File: rtl/instr_fetch_pkg.sv
// Shared constants and fetch-state encoding for the instruction fetch unit.
// FETCH_TIMEOUT_EN adds the ERR state used by the ack timeout.
package instr_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOOP = 32'hFC00_0000;

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, SKID, DISCARD, ERR} fetch_state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, SKID, DISCARD} fetch_state_t;
`endif

endpackage

// File: rtl/fetch_skid.sv
// One-entry PC + instruction holding buffer used when decode is stalled.
// Priority is clear over load over drain.
module fetch_skid
    import instr_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding request, registered output slot,
// one-entry skid buffer and redirect handling. Optional FETCH_TIMEOUT_EN macro.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall_ID,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  Redirect_PC,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC_IF,
    output logic [INSTR_W-1:0] Instruction_IF,
    output logic               fetch_err
);

    fetch_state_t       state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [ADDR_W-1:0]  disc_addr, disc_addr_n;
    logic               slot_valid, slot_valid_n;
    logic [ADDR_W-1:0]  pc_if_n;
    logic [INSTR_W-1:0] instr_if_n;
    logic               slot_free;
    logic               in_err;

    logic               skid_load, skid_drain, skid_clear;
    logic               skid_valid;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             err_n;
    assign in_err = (state == ERR);
`else
    assign in_err    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    fetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            disc_addr      <= RESET_PC;
            slot_valid     <= 1'b0;
            PC_IF          <= '0;
            Instruction_IF <= NOOP;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            disc_addr      <= disc_addr_n;
            slot_valid     <= slot_valid_n;
            PC_IF          <= pc_if_n;
            Instruction_IF <= instr_if_n;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_n;
            fetch_err <= err_n;
        end
    end
`endif

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        disc_addr_n  = disc_addr;
        slot_valid_n = slot_valid;
        pc_if_n      = PC_IF;
        instr_if_n   = Instruction_IF;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;
        imem_req     = (state == REQ) || (state == DISCARD);
        imem_addr    = (state == DISCARD) ? disc_addr : pc;
        slot_free    = !slot_valid || !Stall_ID;

        // Decode takes the presented word on every unstalled edge.
        if (!Stall_ID) begin
            slot_valid_n = 1'b0;
            instr_if_n   = NOOP;
        end

        case (state)
            IDLE: begin
                if (slot_free && !skid_valid) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    pc_n = pc + 32'd4;
                    if (slot_free) begin
                        slot_valid_n = 1'b1;
                        pc_if_n      = pc;
                        instr_if_n   = imem_rdata;
                    end else begin
                        skid_load = 1'b1;
                        state_n   = SKID;
                    end
                end
            end
            SKID: begin
                if (!Stall_ID) begin
                    slot_valid_n = 1'b1;
                    pc_if_n      = skid_pc;
                    instr_if_n   = skid_instr;
                    skid_drain   = 1'b1;
                    state_n      = IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                slot_valid_n = 1'b0;
                instr_if_n   = NOOP;
            end
        endcase

        // Redirect wins over stall and ack; an unanswered request must drain first.
        if (Redirect && !in_err) begin
            pc_n         = Redirect_PC;
            slot_valid_n = 1'b0;
            instr_if_n   = NOOP;
            skid_clear   = 1'b1;
            skid_load    = 1'b0;
            skid_drain   = 1'b0;
            if (state == DISCARD) begin
                state_n = imem_ack ? IDLE : DISCARD;
            end else if (state == REQ && !imem_ack) begin
                state_n     = DISCARD;
                disc_addr_n = pc;
            end else begin
                state_n = REQ;
            end
        end

`ifdef FETCH_TIMEOUT_EN
        err_n      = fetch_err;
        wait_cnt_n = '0;
        if (in_err) begin
            state_n = ERR;
        end else if (imem_req && !imem_ack) begin
            wait_cnt_n = wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_n      = ERR;
                err_n        = 1'b1;
                slot_valid_n = 1'b0;
                instr_if_n   = NOOP;
                skid_clear   = 1'b1;
                skid_load    = 1'b0;
                skid_drain   = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC-ordered scoreboard of consumed words.
module tb_instr_fetch;

    localparam logic [31:0] NOOP_W = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic [31:0] instr_if;
    logic        fetch_err;
    logic        ack_en;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = word_of(imem_addr);

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Stall_ID       (stall),
        .Redirect       (redirect),
        .Redirect_PC    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PC_IF          (pc_if),
        .Instruction_IF (instr_if),
        .fetch_err      (fetch_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every word decode consumes must be the next one the bench expects.
    always @(negedge clk) begin
        if (rst_n && !stall && instr_if !== NOOP_W) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", pc_if, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", pc_if, e);
                check("sb_instr", instr_if, word_of(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ack_en = 1'b0;
        repeat (3) step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc_if", pc_if, 32'd0);
        check("rst_instr", instr_if, NOOP_W);
        check("rst_err", {31'd0, fetch_err}, 32'd0);

        // Streaming with same-cycle ack, then a 3-cycle stall filling the skid.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC); exp_q.push_back(32'h10);
        ack_en = 1'b1;
        rst_n  = 1'b1;
        step();
        step(); check("b2b_pc0", pc_if, 32'h0); check("b2b_in0", instr_if, word_of(32'h0));
        step(); check("b2b_pc4", pc_if, 32'h4);
        step(); check("b2b_pc8", pc_if, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_pc", pc_if, 32'h8);
            check("stall_instr", instr_if, word_of(32'h8));
        end
        stall = 1'b0;
        step(); check("skid_pc", pc_if, 32'hC); check("skid_instr", instr_if, word_of(32'hC));
        step();
        n = 0;
        while (instr_if === NOOP_W && n < 3) begin step(); n++; end
        check("after_skid_pc", pc_if, 32'h10);
        ack_en = 1'b0;

        // Reset mid-request, then redirect with the 0x8 request unanswered.
        step();
        rst_n = 1'b0;
        step(); step();
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        ack_en = 1'b1;
        rst_n  = 1'b1;
        step(); step(); step();
        check("pre_redir_pc", pc_if, 32'h4);
        ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("disc_req", {31'd0, imem_req}, 32'd1);
        check("disc_addr", imem_addr, 32'h8);
        check("disc_noop", instr_if, NOOP_W);
        step();
        check("disc_addr_hold", imem_addr, 32'h8);
        ack_en = 1'b1;
        step();
        check("disc_drop", instr_if, NOOP_W);
        step();
        check("tgt_req", {31'd0, imem_req}, 32'd1);
        check("tgt_addr", imem_addr, 32'h100);
        step();
        check("tgt_pc", pc_if, 32'h100);
        check("tgt_instr", instr_if, word_of(32'h100));

        // Redirect coincident with ack while stalled.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        check("coinc_ack", {31'd0, imem_ack}, 32'd1);
        step();
        check("coinc_noop", instr_if, NOOP_W);
        check("coinc_addr", imem_addr, 32'h200);
        check("coinc_req", {31'd0, imem_req}, 32'd1);

        // Double redirect during DISCARD, then wrap of the fetch PC.
        stall = 1'b0; ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("disc2_addr", imem_addr, 32'h200);
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        ack_en = 1'b1;
        step();
        step();
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc_if", pc_if, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr, 32'h0);
        step();
        check("wrap_pc0", pc_if, 32'h0);
        ack_en = 1'b0;
        step(); step();
        check("sb_drained", exp_q.size(), 32'd0);
        check("no_err", {31'd0, fetch_err}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        while (!imem_req && n < 5) begin step(); n++; end
        check("to_req_seen", {31'd0, imem_req}, 32'd1);
        repeat (3) step();
        check("to_err_early", {31'd0, fetch_err}, 32'd0);
        step();
        check("to_err", {31'd0, fetch_err}, 32'd1);
        check("to_req_off", {31'd0, imem_req}, 32'd0);
        check("to_noop", instr_if, NOOP_W);
        ack_en = 1'b1;
        step(); step();
        check("to_sticky", {31'd0, fetch_err}, 32'd1);
        check("to_req_stays_off", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        step();
        check("to_cleared", {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;
        ack_en = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, max wait cycles for imem_ack (used only under FETCH_TIMEOUT_EN).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 Stall_ID  in  1  1: decode holds, presented word not consumed this edge; 0: consumed.
REQ-006 Redirect  in  1  one-cycle pulse: taken branch/jump, restart fetch.
REQ-007 Redirect_PC  in  32  target address, valid with Redirect.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word address of request.
REQ-010 imem_ack  in  1  one-cycle response strobe, may arrive same cycle as imem_req rises.
REQ-011 imem_rdata  in  32  instruction, valid with imem_ack.
REQ-012 PC_IF  out  32  PC of presented instruction, registered.
REQ-013 Instruction_IF  out  32  presented instruction, 32'hFC00_0000 (NOOP) when slot empty, registered.
REQ-014 fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-015 Output slot (valid bit + PC_IF + Instruction_IF) SHALL be consumed at any edge with Stall_ID=0; while Stall_ID=1, PC_IF/Instruction_IF SHALL hold stable.
REQ-016 States: IDLE, REQ, SKID, DISCARD (plus ERR under FETCH_TIMEOUT_EN).
REQ-017 IDLE->REQ when slot empty or being consumed and skid empty; REQ holds imem_req=1, imem_addr=PC stable until imem_ack.
REQ-018 On imem_ack in REQ: data to output slot if slot empty or consumed this edge, else to one-entry skid buffer (state SKID); PC <= PC+4 (wraps mod 2^32).
REQ-019 SKID: no new request; at first edge with Stall_ID=0, skid moves to output slot, return to IDLE; back-to-back fetch SHALL give one instruction per cycle when ack is same-cycle.
REQ-020 Slot consumed with no new data: Instruction_IF <= NOOP, valid <= 0.
REQ-021 Redirect (priority over Stall_ID and ack): PC <= Redirect_PC, slot and skid cleared (Instruction_IF=NOOP), ack in same cycle discarded; if request outstanding without ack, go DISCARD.
REQ-022 DISCARD keeps imem_req/imem_addr stable until imem_ack, drops data, then IDLE fetching new PC; a second Redirect in DISCARD only updates PC.
REQ-023 Latency: Redirect edge to target word presented = 1 cycle after its imem_ack.

Reset
REQ-024 rst_n low: state IDLE, PC=RESET_PC, PC_IF=0, Instruction_IF=32'hFC00_0000, slot/skid invalid, imem_req=0, fetch_err=0; reset mid-request abandons it, ack arriving after release ignored unless a new request is active.

Configuration
REQ-025 Macro FETCH_TIMEOUT_EN defined: counter counts cycles in REQ/DISCARD without ack; on reaching TIMEOUT_CYCLES, fetch_err <= 1, imem_req <= 0, state ERR, outputs NOOP until reset.
REQ-026 Macro undefined: no counter or ERR state, fetch_err tied 0, wait unbounded.

Structure
REQ-027 Shared package: NOOP constant 32'hFC00_0000, instruction/address width constants, fetch-state enum.
REQ-028 One sub-module fetch_skid (one-entry PC+instruction buffer with load/drain/clear).

Verification
REQ-029 Reset release, same-cycle ack, Stall_ID=0: PCs 0x0,0x4,0x8 presented on consecutive cycles.
REQ-030 Stall_ID=1 for 3 cycles with ack pending: PC_IF/Instruction_IF frozen, second word in skid, no imem_req; release -> 0x4 then 0x8 without gap beyond 1 cycle.
REQ-031 Redirect to 0x100 with request at 0x8 outstanding, ack 2 cycles later: 0x8 data dropped, NOOP presented, next request addr 0x100.
REQ-032 Redirect coincident with imem_ack and Stall_ID=1: data discarded, Instruction_IF=NOOP next cycle, imem_addr=Redirect_PC.
REQ-033 PC 0xFFFF_FFFC fetched: next imem_addr 0x0000_0000.
REQ-034 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack withheld: fetch_err=1 after 4 cycles, imem_req=0, cleared only by rst_n.
